// File: rtl/mem_arbiter_pkg.sv
// ============================================================================
// Module      : mem_arbiter_pkg
// Description : Shared codes for the memory arbiter: access widths, engine
//               op bits, IO address tag, FSM states and owner codes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_arbiter_pkg;

    // Access width codes carried in op[1:0]
    localparam logic [1:0] c_WIDTH_BYTE = 2'd0;
    localparam logic [1:0] c_WIDTH_HALF = 2'd1;
    localparam logic [1:0] c_WIDTH_WORD = 2'd2;

    // mc_op[3]: direction of the engine transaction
    localparam logic c_MC_READ  = 1'b1;
    localparam logic c_MC_WRITE = 1'b0;

    // Fetch is always an unsigned word read
    localparam logic [3:0] c_OP_FETCH = {c_MC_READ, 1'b1, c_WIDTH_WORD};

    // Address bits 17:16 equal to this tag select the IO space
    localparam logic [1:0] c_IO_TAG = 2'b11;

    // FSM state codes
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_BUSY = 2'd1;
    localparam logic [1:0] c_ST_GAP  = 2'd2;

    // Owner of the transaction in flight
    localparam logic [1:0] c_OWN_FETCH = 2'd0;
    localparam logic [1:0] c_OWN_LOAD  = 2'd1;
    localparam logic [1:0] c_OWN_STORE = 2'd2;

    // Bit positions inside the one-hot grant vector
    localparam int c_GNT_FETCH = 0;
    localparam int c_GNT_LOAD  = 1;
    localparam int c_GNT_STORE = 2;

    // True when the address targets the IO space
    function automatic logic is_io_addr(input logic [31:0] addr);
        return (addr[17:16] == c_IO_TAG);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_arbiter_pick.sv
// ============================================================================
// Module      : mem_arbiter_pick
// Description : Combinational priority picker. Store > load > fetch, with a
//               starvation override that hands the grant to a waiting fetch.
//               Output is one-hot (or zero when nothing is eligible).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter_pick
    import mem_arbiter_pkg::*;
(
    input  logic       i_st_elig,
    input  logic       i_ld_elig,
    input  logic       i_if_req,
    input  logic       i_starve,
    output logic [2:0] o_grant
);

    // Fixed priority with the fetch override checked first
    always_comb begin
        o_grant = 3'b000;
        if (i_starve && i_if_req) begin
            o_grant[c_GNT_FETCH] = 1'b1;
        end else if (i_st_elig) begin
            o_grant[c_GNT_STORE] = 1'b1;
        end else if (i_ld_elig) begin
            o_grant[c_GNT_LOAD] = 1'b1;
        end else if (i_if_req) begin
            o_grant[c_GNT_FETCH] = 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module      : mem_arbiter
// Description : Shares the byte-serial memory engine between instruction
//               fetch, LSB load and LSB store. One transaction in flight,
//               IDLE -> BUSY -> GAP sequencing, IO-store blocking, fetch
//               anti-starvation and kill of flushed fetch/load results.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        rdy_in,
    input  logic        clear_in,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ready,
    output logic [31:0] if_data,
    input  logic        ld_req,
    input  logic [31:0] ld_addr,
    input  logic [2:0]  ld_op,
    output logic        ld_ready,
    output logic [31:0] ld_data,
    input  logic        st_req,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    input  logic [1:0]  st_op,
    output logic        st_done,
    input  logic        io_buffer_full,
    output logic        mc_req,
    output logic [31:0] mc_addr,
    output logic [31:0] mc_data,
    output logic [3:0]  mc_op,
    input  logic        mc_done,
    input  logic [31:0] mc_rdata
);

    localparam logic [2:0] c_STARVE_MAX = 3'(STARVE_LIMIT);

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic [2:0]  r_starve_cnt;
    logic        r_kill;
    logic [1:0]  r_owner;

    logic        r_mc_req;
    logic [31:0] r_mc_addr;
    logic [31:0] r_mc_data;
    logic [3:0]  r_mc_op;
    logic        r_if_ready;
    logic [31:0] r_if_data;
    logic        r_ld_ready;
    logic [31:0] r_ld_data;
    logic        r_st_done;

    logic        w_io_block;
    logic        w_st_elig;
    logic        w_ld_elig;
    logic        w_starve;
    logic [2:0]  w_grant;
    logic        w_issue;
    logic        w_finish;
    logic        w_kill_now;
    logic        w_killed;
    logic [1:0]  w_owner;
    logic [31:0] w_addr;
    logic [31:0] w_data;
    logic [3:0]  w_op;

    // A blocked IO store also holds back loads so LSB order is preserved
    assign w_io_block = st_req && is_io_addr(st_addr) && io_buffer_full;
    assign w_st_elig  = st_req && !w_io_block;
    assign w_ld_elig  = ld_req && !w_io_block;
    assign w_starve   = (r_starve_cnt == c_STARVE_MAX);

    mem_arbiter_pick u_pick (
        .i_st_elig (w_st_elig),
        .i_ld_elig (w_ld_elig),
        .i_if_req  (if_req),
        .i_starve  (w_starve),
        .o_grant   (w_grant)
    );

    // Stores always complete visibly; a flush only cancels fetch/load results
    assign w_kill_now = clear_in && (r_owner != c_OWN_STORE);
    assign w_killed   = r_kill || w_kill_now;

    // Fields of the winning request, latched into mc_* on issue
    always_comb begin
        w_owner = c_OWN_FETCH;
        w_addr  = if_addr;
        w_data  = 32'd0;
        w_op    = c_OP_FETCH;
        if (w_grant[c_GNT_STORE]) begin
            w_owner = c_OWN_STORE;
            w_addr  = st_addr;
            w_data  = st_data;
            w_op    = {c_MC_WRITE, 1'b0, st_op};
        end else if (w_grant[c_GNT_LOAD]) begin
            w_owner = c_OWN_LOAD;
            w_addr  = ld_addr;
            w_op    = {c_MC_READ, ld_op};
        end
    end

    // Next-state logic and the issue/finish strobes it implies
    always_comb begin
        w_state_next = r_state;
        w_issue      = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (|w_grant) begin
                    w_state_next = c_ST_BUSY;
                    w_issue      = 1'b1;
                end
            end
            c_ST_BUSY: begin
                if (mc_done) begin
                    w_state_next = c_ST_GAP;
                    w_finish     = 1'b1;
                end
            end
            c_ST_GAP: begin
                w_state_next = c_ST_IDLE;
            end
            default: begin
                w_state_next = c_ST_IDLE;
            end
        endcase
    end

    // State register; rdy_in low freezes everything
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state <= c_ST_IDLE;
        end else if (rdy_in) begin
            r_state <= w_state_next;
        end
    end

    // Engine interface, owner/kill tracking and completion pulses
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_mc_req   <= 1'b0;
            r_mc_addr  <= 32'd0;
            r_mc_data  <= 32'd0;
            r_mc_op    <= 4'd0;
            r_owner    <= c_OWN_FETCH;
            r_kill     <= 1'b0;
            r_if_ready <= 1'b0;
            r_if_data  <= 32'd0;
            r_ld_ready <= 1'b0;
            r_ld_data  <= 32'd0;
            r_st_done  <= 1'b0;
        end else if (rdy_in) begin
            r_if_ready <= 1'b0;
            r_ld_ready <= 1'b0;
            r_st_done  <= 1'b0;
            if (w_issue) begin
                r_mc_req  <= 1'b1;
                r_mc_addr <= w_addr;
                r_mc_data <= w_data;
                r_mc_op   <= w_op;
                r_owner   <= w_owner;
                r_kill    <= 1'b0;
            end else if (w_finish) begin
                r_mc_req <= 1'b0;
                r_kill   <= 1'b0;
                case (r_owner)
                    c_OWN_FETCH: begin
                        if (!w_killed) begin
                            r_if_ready <= 1'b1;
                            r_if_data  <= mc_rdata;
                        end
                    end
                    c_OWN_LOAD: begin
                        if (!w_killed) begin
                            r_ld_ready <= 1'b1;
                            r_ld_data  <= mc_rdata;
                        end
                    end
                    default: begin
                        r_st_done <= 1'b1;
                    end
                endcase
            end else if ((r_state == c_ST_BUSY) && w_kill_now) begin
                r_kill <= 1'b1;
            end
        end
    end

    // Count data grants that overtook a waiting fetch; a fetch grant resets it
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_starve_cnt <= 3'd0;
        end else if (rdy_in && w_issue) begin
            if (w_grant[c_GNT_FETCH]) begin
                r_starve_cnt <= 3'd0;
            end else if (if_req && (r_starve_cnt != c_STARVE_MAX)) begin
                r_starve_cnt <= r_starve_cnt + 3'd1;
            end
        end
    end

    assign mc_req   = r_mc_req;
    assign mc_addr  = r_mc_addr;
    assign mc_data  = r_mc_data;
    assign mc_op    = r_mc_op;
    assign if_ready = r_if_ready;
    assign if_data  = r_if_data;
    assign ld_ready = r_ld_ready;
    assign ld_data  = r_ld_data;
    assign st_done  = r_st_done;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Scoreboard bench for mem_arbiter with a behavioural engine.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int c_ENG_LAT = 4;
    localparam int c_EV_GRANT = 0;
    localparam int c_EV_IF    = 1;
    localparam int c_EV_LD    = 2;
    localparam int c_EV_ST    = 3;

    logic        clk_in = 1'b0;
    logic        rst_n_in = 1'b0;
    logic        rdy_in = 1'b1;
    logic        clear_in = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'd0;
    logic        if_ready;
    logic [31:0] if_data;
    logic        ld_req = 1'b0;
    logic [31:0] ld_addr = 32'd0;
    logic [2:0]  ld_op = 3'd0;
    logic        ld_ready;
    logic [31:0] ld_data;
    logic        st_req = 1'b0;
    logic [31:0] st_addr = 32'd0;
    logic [31:0] st_data = 32'd0;
    logic [1:0]  st_op = 2'd0;
    logic        st_done;
    logic        io_buffer_full = 1'b0;
    logic        mc_req;
    logic [31:0] mc_addr;
    logic [31:0] mc_data;
    logic [3:0]  mc_op;
    logic        mc_done = 1'b0;
    logic [31:0] mc_rdata = 32'd0;

    mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk_in         (clk_in),
        .rst_n_in       (rst_n_in),
        .rdy_in         (rdy_in),
        .clear_in       (clear_in),
        .if_req         (if_req),
        .if_addr        (if_addr),
        .if_ready       (if_ready),
        .if_data        (if_data),
        .ld_req         (ld_req),
        .ld_addr        (ld_addr),
        .ld_op          (ld_op),
        .ld_ready       (ld_ready),
        .ld_data        (ld_data),
        .st_req         (st_req),
        .st_addr        (st_addr),
        .st_data        (st_data),
        .st_op          (st_op),
        .st_done        (st_done),
        .io_buffer_full (io_buffer_full),
        .mc_req         (mc_req),
        .mc_addr        (mc_addr),
        .mc_data        (mc_data),
        .mc_op          (mc_op),
        .mc_done        (mc_done),
        .mc_rdata       (mc_rdata)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [3:0]  op;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          ld_again = 0;
    logic        eng_force = 1'b0;
    logic [31:0] eng_force_val = 32'd0;

    function automatic logic [31:0] rdata_for(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic push_grant(input logic [31:0] a, input logic [3:0] op, input logic [31:0] d);
        exp_t e;
        e.kind = c_EV_GRANT; e.addr = a; e.op = op; e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic push_resp(input int k, input logic [31:0] d);
        exp_t e;
        e.kind = k; e.addr = 32'd0; e.op = 4'd0; e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Engine model: counts only unfrozen cycles, holds mc_done until consumed
    logic rdy_seen = 1'b1;
    always @(posedge clk_in) rdy_seen <= rdy_in;

    int   eng_cnt = 0;
    logic eng_busy = 1'b0;
    always @(negedge clk_in) begin
        if (!rst_n_in) begin
            mc_done  = 1'b0;
            eng_busy = 1'b0;
            eng_cnt  = 0;
        end else if (mc_done) begin
            if (!mc_req) begin
                mc_done  = 1'b0;
                eng_busy = 1'b0;
            end
        end else if (rdy_seen) begin
            if (mc_req && !eng_busy) begin
                eng_busy = 1'b1;
                eng_cnt  = c_ENG_LAT;
            end else if (eng_busy) begin
                if (eng_cnt <= 1) begin
                    mc_done  = 1'b1;
                    mc_rdata = eng_force ? eng_force_val : rdata_for(mc_addr);
                end else begin
                    eng_cnt--;
                end
            end
        end
    end

    // Monitor: compares every grant and completion pulse with the scoreboard
    task automatic observe(input int k, input logic [31:0] a, input logic [3:0] op, input logic [31:0] d);
        exp_t e;
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: got kind=%0d addr=%h op=%h data=%h, required none", k, a, op, d);
            return;
        end
        e = exp_q.pop_front();
        if (e.kind != k) begin
            n_fail++;
            $display("FAIL event_kind: got kind=%0d addr=%h data=%h, required kind=%0d addr=%h data=%h",
                     k, a, d, e.kind, e.addr, e.data);
        end else if (k == c_EV_GRANT) begin
            if (a !== e.addr || op !== e.op || (e.op[3] == 1'b0 && d !== e.data)) begin
                n_fail++;
                $display("FAIL grant: got addr=%h op=%h data=%h, required addr=%h op=%h data=%h",
                         a, op, d, e.addr, e.op, e.data);
            end
        end else if (d !== e.data) begin
            n_fail++;
            $display("FAIL response_data kind=%0d: got %h, required %h", k, d, e.data);
        end
    endtask

    logic mon_prev_req = 1'b0;
    always @(negedge clk_in) begin
        if (!rst_n_in) begin
            mon_prev_req = 1'b0;
        end else begin
            if (mc_req && !mon_prev_req) observe(c_EV_GRANT, mc_addr, mc_op, mc_data);
            if (if_ready) observe(c_EV_IF, 32'd0, 4'd0, if_data);
            if (ld_ready) observe(c_EV_LD, 32'd0, 4'd0, ld_data);
            if (st_done)  observe(c_EV_ST, 32'd0, 4'd0, 32'd0);
            mon_prev_req = mc_req;
        end
    end

    // One cycle; requesters drop (or re-raise) their request on completion
    task automatic tick();
        @(negedge clk_in);
        if (if_ready) if_req = 1'b0;
        if (st_done)  st_req = 1'b0;
        if (ld_ready) begin
            if (ld_again > 0) begin
                ld_again--;
                ld_addr = ld_addr + 32'd4;
            end else begin
                ld_req = 1'b0;
            end
        end
    endtask

    task automatic drain(input string name);
        int i;
        i = 0;
        while (exp_q.size() != 0 && i < 300) begin
            tick();
            i++;
        end
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: %0d events pending after %0d cycles, required 0", name, exp_q.size(), i);
            exp_q.delete();
        end
        repeat (4) tick();
    endtask

    task automatic wait_grant(input string name);
        int i;
        i = 0;
        while (!mc_req && i < 50) begin
            tick();
            i++;
        end
        if (!mc_req) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: got no mc_req within 50 cycles, required grant", name);
        end
    endtask

    task automatic tb_reset();
        rst_n_in = 1'b0;
        if_req = 1'b0; ld_req = 1'b0; st_req = 1'b0;
        clear_in = 1'b0; rdy_in = 1'b1; io_buffer_full = 1'b0;
        ld_again = 0; eng_force = 1'b0;
        repeat (2) @(negedge clk_in);
        rst_n_in = 1'b1;
        tick();
    endtask

    task automatic fetch_latency(input logic [31:0] a, input bit freeze, input int req_k, input string name);
        int k;
        if_addr = a; if_req = 1'b1;
        push_grant(a, c_OP_FETCH, 32'd0);
        push_resp(c_EV_IF, rdata_for(a));
        wait_grant(name);
        k = 0;
        do begin
            tick();
            k++;
            if (freeze && k == 4) rdy_in = 1'b0;
            if (freeze && k == 7) rdy_in = 1'b1;
        end while (!if_ready && k < 40);
        chk(name, 32'(k), 32'(req_k));
        drain(name);
    endtask

    initial begin
        // Reset values
        repeat (3) @(negedge clk_in);
        chk("rst_mc_req",  {31'd0, mc_req},   32'd0);
        chk("rst_mc_op",   {28'd0, mc_op},    32'd0);
        rst_n_in = 1'b1;
        tick();
        chk("rst_if_ready", {31'd0, if_ready}, 32'd0);
        chk("rst_ld_ready", {31'd0, ld_ready}, 32'd0);
        chk("rst_st_done",  {31'd0, st_done},  32'd0);
        chk("rst_mc_addr",  mc_addr, 32'd0);
        chk("rst_mc_data",  mc_data, 32'd0);
        chk("rst_if_data",  if_data, 32'd0);
        chk("rst_ld_data",  ld_data, 32'd0);
        chk("rst_state",    {30'd0, dut.r_state}, {30'd0, c_ST_IDLE});
        chk("rst_starve",   {29'd0, dut.r_starve_cnt}, 32'd0);
        chk("rst_kill",     {31'd0, dut.r_kill}, 32'd0);

        // Three-way collision: store, then load, then fetch
        if_addr = 32'h0000_1000; if_req = 1'b1;
        ld_addr = 32'h0000_2004; ld_op = 3'b010; ld_req = 1'b1;
        st_addr = 32'h0000_3008; st_data = 32'h1122_3344; st_op = 2'b10; st_req = 1'b1;
        push_grant(32'h0000_3008, 4'b0010, 32'h1122_3344);
        push_resp(c_EV_ST, 32'd0);
        push_grant(32'h0000_2004, 4'b1010, 32'd0);
        push_resp(c_EV_LD, rdata_for(32'h0000_2004));
        push_grant(32'h0000_1000, 4'b1110, 32'd0);
        push_resp(c_EV_IF, rdata_for(32'h0000_1000));
        drain("collision");

        // Starvation: four loads overtake the fetch, the fifth grant is the fetch
        tb_reset();
        if_addr = 32'h0000_1100; if_req = 1'b1;
        ld_addr = 32'h0000_2000; ld_op = 3'b000; ld_req = 1'b1; ld_again = 4;
        for (int i = 0; i < 4; i++) begin
            push_grant(32'h0000_2000 + 32'(4 * i), 4'b1000, 32'd0);
            push_resp(c_EV_LD, rdata_for(32'h0000_2000 + 32'(4 * i)));
        end
        push_grant(32'h0000_1100, 4'b1110, 32'd0);
        push_resp(c_EV_IF, rdata_for(32'h0000_1100));
        push_grant(32'h0000_2010, 4'b1000, 32'd0);
        push_resp(c_EV_LD, rdata_for(32'h0000_2010));
        drain("starvation");
        chk("starve_after_fetch", {29'd0, dut.r_starve_cnt}, 32'd0);

        // IO block: fetch passes, load and IO store wait for the buffer
        tb_reset();
        io_buffer_full = 1'b1;
        st_addr = 32'h0003_0000; st_data = 32'h0000_00A5; st_op = 2'b00; st_req = 1'b1;
        ld_addr = 32'h0000_2100; ld_op = 3'b100; ld_req = 1'b1;
        if_addr = 32'h0000_1200; if_req = 1'b1;
        push_grant(32'h0000_1200, 4'b1110, 32'd0);
        push_resp(c_EV_IF, rdata_for(32'h0000_1200));
        drain("io_fetch");
        repeat (6) tick();
        chk("io_hold_mc_req", {31'd0, mc_req}, 32'd0);
        push_grant(32'h0003_0000, 4'b0000, 32'h0000_00A5);
        push_resp(c_EV_ST, 32'd0);
        push_grant(32'h0000_2100, 4'b1100, 32'd0);
        push_resp(c_EV_LD, rdata_for(32'h0000_2100));
        io_buffer_full = 1'b0;
        drain("io_release");

        // Kill: flushed load produces no ld_ready but still passes GAP
        tb_reset();
        eng_force = 1'b1; eng_force_val = 32'hDEAD_BEEF;
        ld_addr = 32'h0000_2200; ld_op = 3'b101; ld_req = 1'b1;
        push_grant(32'h0000_2200, 4'b1101, 32'd0);
        wait_grant("kill_grant");
        tick();
        tick();
        clear_in = 1'b1; ld_req = 1'b0;
        tick();
        clear_in = 1'b0;
        for (int i = 0; i < 50 && mc_req; i++) tick();
        chk("kill_state_gap", {30'd0, dut.r_state}, {30'd0, c_ST_GAP});
        chk("kill_ld_ready", {31'd0, ld_ready}, 32'd0);
        repeat (3) tick();
        chk("kill_ld_data", ld_data, 32'd0);
        eng_force = 1'b0;
        st_addr = 32'h0000_3300; st_data = 32'hCAFE_F00D; st_op = 2'b01; st_req = 1'b1;
        push_grant(32'h0000_3300, 4'b0001, 32'hCAFE_F00D);
        push_resp(c_EV_ST, 32'd0);
        drain("kill_store");

        // Freeze: baseline 5 cycles grant-to-ready, 3 frozen cycles add 3
        tb_reset();
        fetch_latency(32'h0000_1300, 1'b0, 5, "latency_base");
        fetch_latency(32'h0000_1310, 1'b1, 8, "latency_freeze");

        // Async reset in the middle of a load transaction
        tb_reset();
        if_addr = 32'h0000_1400; if_req = 1'b1;
        ld_addr = 32'h0000_2300; ld_op = 3'b010; ld_req = 1'b1;
        push_grant(32'h0000_2300, 4'b1010, 32'd0);
        wait_grant("areset_grant");
        tick();
        tick();
        chk("areset_pre_starve", {29'd0, dut.r_starve_cnt}, 32'd1);
        #2;
        rst_n_in = 1'b0;
        #1;
        chk("areset_mc_req", {31'd0, mc_req}, 32'd0);
        chk("areset_state",  {30'd0, dut.r_state}, {30'd0, c_ST_IDLE});
        chk("areset_starve", {29'd0, dut.r_starve_cnt}, 32'd0);
        if_req = 1'b0; ld_req = 1'b0;
        tick();
        rst_n_in = 1'b1;
        repeat (4) tick();
        chk("areset_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
